cube_root: RTL and testbench

Sequential integer cube-root unit. It extracts one root bit per clock, restoring digit-by-digit, MSB first, and produces a signed root and a signed remainder. It is built from three sub-blocks:
- Iterator: bit-position counter.
- Factor: trial-cube generator.
- DataPath: compare/accept logic, root and remainder registers, sign handling.

It sits as a multi-cycle arithmetic slave: the host holds the operand, releases reset, and reads the result a fixed number of cycles later.

---
 rtl/cube_root_if.sv | 11 +
 rtl/cube_root.sv | 67 ++++++
 tb/tb_cube_root.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cube_root_if.sv
// Operand/result bundle for the sequential cube-root unit.
// The host drives D/sign and samples rez/r once the fixed latency has elapsed.
interface cube_root_if;
  logic [31:0] D;
  logic        sign;
  logic [10:0] rez;
  logic [32:0] r;

  modport master (output D, output sign, input rez, input r);
  modport slave  (input D, input sign, output rez, output r);
endinterface

// File: rtl/cube_root.sv
// Restoring digit-by-digit integer cube root, one root bit per clock, MSB first.
// Produces a signed root and a signed remainder from a sign/magnitude operand.
module cube_root (
  input  logic        clk,
  input  logic        rst,
  cube_root_if.slave  bus
);

  logic [3:0]  i_q, i_d;
  logic [9:0]  q_q, q_d;
  logic [29:0] rem_q, rem_d;

  logic [29:0] m;
  logic        unused_hi;
  logic        active;
  logic [29:0] rem_cur;
  logic [10:0] t;
  logic [32:0] t_ext;
  logic [32:0] f;
  logic        accept;
  logic [10:0] q_ext;
  logic [32:0] rem_ext;

  assign m         = bus.D[29:0];
  assign unused_hi = ^bus.D[31:30];

  // rem_q is only meaningful once the first edge has passed; at i=10 the
  // remainder is the operand itself, so it tracks D while reset is held.
  assign active  = (i_q <= 4'd10);
  assign rem_cur = (i_q == 4'd10) ? m : rem_q;

  assign t     = {1'b0, q_q} | (11'd1 << i_q);
  assign t_ext = {22'd0, t};
  assign f     = t_ext * t_ext * t_ext;
  assign accept = active && (f <= {3'd0, m});

  always_comb begin
    i_d   = i_q;
    q_d   = q_q;
    rem_d = rem_cur;
    if (active) begin
      i_d = (i_q == 4'd0) ? 4'd15 : i_q - 4'd1;
      if (accept) begin
        q_d   = t[9:0];
        rem_d = m - f[29:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q   <= 4'd10;
      q_q   <= 10'd0;
      rem_q <= 30'd0;
    end else begin
      i_q   <= i_d;
      q_q   <= q_d;
      rem_q <= rem_d;
    end
  end

  assign q_ext   = {1'b0, q_q};
  assign rem_ext = {3'd0, rem_cur};
  assign bus.rez = bus.sign ? q_ext : -q_ext;
  assign bus.r   = bus.sign ? rem_ext : -rem_ext;

endmodule

// File: tb/tb_cube_root.sv
// Directed-vector bench for cube_root: table of operands with hand-computed
// roots/remainders, plus a mid-computation reset sequence.
module tb_cube_root;

  logic clk;
  logic rst;
  cube_root_if bus ();

  cube_root dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        s;
    logic [31:0] d;
    longint      exp_rez;
    longint      exp_r;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    longint m;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    bus.D    = 32'd0;
    bus.sign = 1'b1;

    vecs[0]  = '{1'b1, 32'd1000,       10,    0};
    vecs[1]  = '{1'b0, 32'd421,        -7,   -78};
    vecs[2]  = '{1'b1, 32'd421,         7,    78};
    vecs[3]  = '{1'b1, 32'd75366,      42,  1278};
    vecs[4]  = '{1'b1, 32'd1730482,   120,  2482};
    // 1023^3 = 1070599167, so the remainder of 2^30-1 is 3142656
    vecs[5]  = '{1'b1, 32'h3FFF_FFFF, 1023, 3142656};
    vecs[6]  = '{1'b1, 32'd0,           0,     0};
    vecs[7]  = '{1'b1, 32'd1,           1,     0};
    vecs[8]  = '{1'b0, 32'd7,          -1,    -6};
    vecs[9]  = '{1'b1, 32'd26,          2,    18};
    vecs[10] = '{1'b1, 32'd27,          3,     0};
    vecs[11] = '{1'b1, 32'hC000_0008,   2,     0};   // D[31:30] ignored
    vecs[12] = '{1'b0, 32'h3FFF_FFFF, -1023, -3142656};

    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      rst      = 1'b0;
      bus.D    = vecs[k].d;
      bus.sign = vecs[k].s;
      #1;
      m = longint'(vecs[k].d[29:0]);
      check($sformatf("v%0d reset rez", k), longint'($signed(bus.rez)), 0);
      check($sformatf("v%0d reset r", k), longint'($signed(bus.r)), vecs[k].s ? m : -m);
      rst = 1'b1;
      edges(11);
      check($sformatf("v%0d rez", k), longint'($signed(bus.rez)), vecs[k].exp_rez);
      check($sformatf("v%0d r", k), longint'($signed(bus.r)), vecs[k].exp_r);
      edges(3);
      check($sformatf("v%0d done rez", k), longint'($signed(bus.rez)), vecs[k].exp_rez);
      check($sformatf("v%0d done r", k), longint'($signed(bus.r)), vecs[k].exp_r);
      @(negedge clk);
      bus.sign = ~bus.sign;
      #1;
      check($sformatf("v%0d flip rez", k), longint'($signed(bus.rez)), -vecs[k].exp_rez);
      check($sformatf("v%0d flip r", k), longint'($signed(bus.r)), -vecs[k].exp_r);
    end

    // Abort a run after 5 edges: bits 10..6 of 120 resolved gives q=64
    @(negedge clk);
    rst      = 1'b0;
    bus.D    = 32'd1730482;
    bus.sign = 1'b1;
    #1;
    rst = 1'b1;
    edges(5);
    check("mid rez", longint'($signed(bus.rez)), 64);
    check("mid r", longint'($signed(bus.r)), 1730482 - 262144);
    #2;
    rst = 1'b0;
    #1;
    check("abort rez", longint'($signed(bus.rez)), 0);
    check("abort r", longint'($signed(bus.r)), 1730482);
    bus.D = 32'd5000;
    #1;
    check("track r", longint'($signed(bus.r)), 5000);

    // Spec sequence: new run with D=0, reset asserted at cycle 5
    @(negedge clk);
    bus.D = 32'd0;
    rst   = 1'b1;
    edges(5);
    #2;
    rst = 1'b0;
    #1;
    check("zero abort rez", longint'($signed(bus.rez)), 0);
    check("zero abort r", longint'($signed(bus.r)), 0);
    @(negedge clk);
    rst = 1'b1;
    edges(11);
    check("zero rez", longint'($signed(bus.rez)), 0);
    check("zero r", longint'($signed(bus.r)), 0);

    // Restart after abort must run cleanly from bit 10
    @(negedge clk);
    rst   = 1'b0;
    bus.D = 32'd75366;
    #1;
    rst = 1'b1;
    edges(11);
    check("restart rez", longint'($signed(bus.rez)), 42);
    check("restart r", longint'($signed(bus.r)), 1278);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
